// File: rtl/rrc_pkg.sv
// Shared types and constants for the folded root-raised-cosine FIR controller.
package rrc_pkg;

  localparam int COEFF = 33;  // taps, also depth of the sample ring
  localparam int DW    = 16;  // sample / coefficient width
  localparam int AW    = 32;  // accumulator / result width
  localparam int SHIFT = 8;   // output arithmetic right shift
  localparam int IW    = 6;   // width of tap indices and ring pointers

  localparam logic [IW-1:0] NTAP = IW'(COEFF);

  typedef logic signed [DW-1:0] sample_t;
  typedef logic signed [DW-1:0] coeff_t;
  typedef logic signed [AW-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Ring position of sample x[n-k] when x[n] sits at base: (base - k) mod COEFF.
  function automatic logic [IW-1:0] tap_index(input logic [IW-1:0] base,
                                              input logic [IW-1:0] k);
    if (base >= k) return base - k;
    else           return base + NTAP - k;
  endfunction

endpackage

// File: rtl/rrc_mac_unit.sv
// Shared multiply-accumulate: one signed DWxDW product per clock added into
// a wrapping AW-bit accumulator. sum_o is the value the accumulator takes on
// the next enabled edge, so the caller can capture the final sum directly.
module rrc_mac_unit
  import rrc_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    clr_i,
  input  logic    en_i,
  input  coeff_t  coeff_i,
  input  sample_t sample_i,
  output acc_t    sum_o
);

  logic signed [2*DW-1:0] prod;
  acc_t                   acc_q;

  assign prod  = coeff_i * sample_i;
  assign sum_o = acc_q + acc_t'(prod);

  // Accumulator register: clear starts a new output, enable adds one tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        acc_q <= '0;
    else if (clr_i) acc_q <= '0;
    else if (en_i)  acc_q <= sum_o;
  end

endmodule

// File: rtl/rrc_mac_scheduler.sv
// Folded RRC FIR controller. A sample is accepted in IDLE, COEFF taps are
// walked one per clock in MAC, and the shifted result is held in OUT until
// the consumer takes it.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds with its data stable until that edge.
module rrc_mac_scheduler
  import rrc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] dout,
  input  logic          cfg_we,
  input  logic [5:0]    cfg_addr,
  input  logic [DW-1:0] cfg_data,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  state_t          state_q, state_d;
  logic [IW-1:0]   wp_q, base_q, k_q;
  sample_t         buf_q   [COEFF];
  coeff_t          coeff_q [COEFF];
  logic            out_valid_q;
  acc_t            dout_q;
  acc_t            mac_sum;

  logic            accept, last_tap, handshake, cfg_wr_ok;
  logic [IW-1:0]   wp_next, rd_idx;

  assign accept    = (state_q == IDLE) && in_valid;
  assign last_tap  = (state_q == MAC) && (k_q == NTAP - 1'b1);
  assign handshake = (state_q == OUT) && out_ready;
  assign cfg_wr_ok = (state_q == IDLE) && cfg_we && (cfg_addr < NTAP);
  assign wp_next   = (wp_q == NTAP - 1'b1) ? '0 : wp_q + 1'b1;
  assign rd_idx    = tap_index(base_q, k_q);

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign dbg_state = state_q;

  rrc_mac_unit u_mac (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (accept),
    .en_i     (state_q == MAC),
    .coeff_i  (coeff_q[k_q]),
    .sample_i (buf_q[rd_idx]),
    .sum_o    (mac_sum)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: IDLE -> MAC on accept, MAC -> OUT after the last tap,
  // OUT -> IDLE when the result is taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = MAC;
      MAC:     if (last_tap)  state_d = OUT;
      OUT:     if (handshake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: coefficient file, sample ring, pointers and the
  // output holding register. The result is captured from the final MAC sum
  // so it is ready on the same edge the FSM enters OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q        <= '0;
      base_q      <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      for (int i = 0; i < COEFF; i++) begin
        buf_q[i]   <= '0;
        coeff_q[i] <= '0;
      end
    end else begin
      if (cfg_wr_ok) coeff_q[cfg_addr] <= coeff_t'(cfg_data);
      if (accept) begin
        buf_q[wp_q] <= sample_t'(din);
        base_q      <= wp_q;
        wp_q        <= wp_next;
        k_q         <= '0;
      end else if (state_q == MAC) begin
        k_q <= k_q + 1'b1;
      end
      if (last_tap) begin
        out_valid_q <= 1'b1;
        dout_q      <= mac_sum >>> SHIFT;
      end else if (handshake) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
